serial_demux_1to2: RTL and testbench
====================================

// Module: serial_demux_1to2
// PURPOSE
//  Receive-side counterpart of the balanced 2:1 output mux: recovers two WORD_W-bit lanes from one
//  bit-interleaved serial stream (even bits = lane 0 / D0 side, odd bits = lane 1 / D1 side).
//  Finds word and lane alignment from a sync pair, then emits one word pair per 2*WORD_W input bits.
//  Used in the test and emulation fabric to check the chip's muxed readout path.
// PARAMETERS
//  WORD_W      8      bits per lane word; MSB arrives first
//  SYNC_PAT    8'hBC  lane-0 sync word; lane 1 carries ~SYNC_PAT in the same pair
//  SYNC_NEED   4      consecutive sync pairs needed in VERIFY to reach LOCKED
//  SYNC_TMO    64     word pairs allowed in LOCKED without a sync pair before lock is lost
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  din        in   1       interleaved serial bit
//  din_en     in   1       din is valid this cycle; when low, all state holds
//  dout0      out  WORD_W  recovered lane-0 word
//  dout1      out  WORD_W  recovered lane-1 word
//  dout_valid out  1       one-cycle strobe: dout0/dout1 hold a new data pair
//  sync_seen  out  1       one-cycle strobe: a sync pair was absorbed
//  locked     out  1       high in LOCKED
//  lock_lost  out  1       one-cycle strobe on the LOCKED->HUNT transition
// BEHAVIOUR
//  Reset: all outputs 0, state HUNT, window/counters 0. rst dominates every other event, including mid-word.
//  Window: 2*WORD_W-bit raw shift register, shifted in on every din_en cycle. The de-interleave of
//   the window (even positions -> lane0, odd -> lane1) is the candidate pair. bitcnt counts 0..2*WORD_W-1
//   and wraps on enabled cycles.
//  Sync match: lane0==SYNC_PAT && lane1==~SYNC_PAT, evaluated on the post-shift window.
//  FSM:
//   HUNT   : test the match on every enabled bit (bit-slip search). On a match: bitcnt:=0, goodcnt:=1, ->VERIFY.
//   VERIFY : test only at a word boundary (bitcnt wraps). Match: goodcnt++. At goodcnt==SYNC_NEED ->LOCKED.
//            Mismatch: ->HUNT, goodcnt:=0.
//   LOCKED : at each boundary, a sync pair pulses sync_seen and clears tmo. It does not assert dout_valid.
//            Any other pair loads dout0/dout1, pulses dout_valid and increments tmo.
//            When tmo reaches SYNC_TMO: ->HUNT, pulse lock_lost, locked:=0. The pair that hits the timeout
//            is still output.
//  Latency: dout_valid, sync_seen and lock_lost are registered. They assert in the cycle after the clock
//   edge that samples the last bit of the pair.
//  dout0/dout1 hold their value between strobes. They are not cleared on lock loss.
//  din_en low: no shift, no bitcnt/tmo change, no strobes. Gaps of any length are transparent.
//  Lane order is fixed by the sync pair. A stream with lanes swapped never matches: it stays in HUNT.
//  Counter widths: bitcnt $clog2(2*WORD_W); tmo $clog2(SYNC_TMO+1); goodcnt $clog2(SYNC_NEED+1).
// STRUCTURE
//  Shared include serial_demux_defs.vh holds:
//   - state encodings ST_HUNT=2'd0, ST_VERIFY=2'd1, ST_LOCKED=2'd2 (2'd3 decodes to HUNT);
//   - the default SYNC_PAT.
//  One sub-module, demux_deinterleave. It is combinational, maps the raw window to lane0/lane1, and
//   flags sync_match. The FSM, counters and output registers stay in serial_demux_1to2.
// TESTING
//  1 Reset then 4 sync pairs (BC/43) from bit 0, then pair A5/5A.
//    -> locked=1 one cycle after the 4th pair; dout0=A5, dout1=5A, dout_valid one cycle.
//  2 Prefix 3 junk bits before stream 1. -> HUNT slips to alignment. Same outputs.
//    No dout_valid before locked.
//  3 In VERIFY, corrupt the 2nd sync pair (BD/43). -> back to HUNT, locked stays 0.
//    Relock after 4 more good pairs.
//  4 LOCKED, then 64 data pairs with no sync.
//    -> 64 dout_valid strobes; lock_lost pulses with the 64th; locked=0.
//  5 Random din_en gaps (30% low) over test 1. -> identical dout sequence; strobes only after enabled bits.
//  6 rst pulse mid-word while LOCKED. -> all outputs 0 immediately; relock needs 4 fresh sync pairs.

Source files
------------

// File: rtl/serial_demux_1to2_pkg.sv
// ---------------------------------------------------------------------------
// serial_demux_1to2_pkg
//   Shared definitions for the 1:2 serial demultiplexer:
//     - lock FSM state type (HUNT / VERIFY / LOCKED)
//     - default lane width and lane-0 sync word
//   Imported by serial_demux_1to2 and demux_deinterleave.
// ---------------------------------------------------------------------------
package serial_demux_1to2_pkg;

  // Encoding kept identical to the legacy defines; the unused code 2'd3
  // is treated as HUNT by the FSM's default branch.
  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam int unsigned WORD_W_DEFAULT   = 8;
  localparam logic [7:0]  SYNC_PAT_DEFAULT = 8'hBC;

endpackage : serial_demux_1to2_pkg

// File: rtl/demux_deinterleave.sv
// ---------------------------------------------------------------------------
// demux_deinterleave
//   Combinational de-interleave of a 2*WORD_W-bit raw window into two lane
//   words, plus the sync-pair detector.
//   The window is a shift register fed LSB-first in time, so the oldest bit
//   sits in the MSB. Stream bit 0 (even) is lane-0's MSB, bit 1 (odd) is
//   lane-1's MSB, and so on.
//
//   Ports
//     i_win         in   2*WORD_W  raw window, oldest bit in MSB
//     o_lane0       out  WORD_W    even stream positions (D0 side)
//     o_lane1       out  WORD_W    odd stream positions  (D1 side)
//     o_sync_match  out  1         lane0 == SYNC_PAT and lane1 == ~SYNC_PAT
// ---------------------------------------------------------------------------
module demux_deinterleave
  import serial_demux_1to2_pkg::*;
#(
  parameter int unsigned       WORD_W   = WORD_W_DEFAULT,
  parameter logic [WORD_W-1:0] SYNC_PAT = WORD_W'(SYNC_PAT_DEFAULT)
) (
  input  logic [2*WORD_W-1:0] i_win,
  output logic [WORD_W-1:0]   o_lane0,
  output logic [WORD_W-1:0]   o_lane1,
  output logic                o_sync_match
);

  always_comb begin
    o_lane0 = '0;
    o_lane1 = '0;
    for (int unsigned k = 0; k < WORD_W; k++) begin
      // Window bit 2k+1 is older than 2k, so it is the even (lane-0) slot.
      o_lane0[k] = i_win[2*k+1];
      o_lane1[k] = i_win[2*k];
    end
  end

  assign o_sync_match = (o_lane0 == SYNC_PAT) && (o_lane1 == ~SYNC_PAT);

endmodule : demux_deinterleave

// File: rtl/serial_demux_1to2.sv
// ---------------------------------------------------------------------------
// serial_demux_1to2
//   Receive side of the balanced 2:1 output mux. Recovers two WORD_W-bit
//   lanes from one bit-interleaved serial stream (even bits lane 0, odd bits
//   lane 1, MSB first). Alignment is found by a bit-slip search for a sync
//   pair (SYNC_PAT / ~SYNC_PAT), confirmed over SYNC_NEED consecutive pairs,
//   and dropped after SYNC_TMO data pairs without a sync pair.
//
//   Ports
//     clk         in   1       rising-edge clock
//     rst         in   1       asynchronous, active-high reset
//     din         in   1       interleaved serial bit
//     din_en      in   1       din valid; when low all state holds
//     dout0       out  WORD_W  recovered lane-0 word (holds between strobes)
//     dout1       out  WORD_W  recovered lane-1 word (holds between strobes)
//     dout_valid  out  1       strobe: new data pair on dout0/dout1
//     sync_seen   out  1       strobe: sync pair absorbed while locked
//     locked      out  1       high while in LOCKED
//     lock_lost   out  1       strobe on LOCKED -> HUNT
// ---------------------------------------------------------------------------
module serial_demux_1to2
  import serial_demux_1to2_pkg::*;
#(
  parameter int unsigned       WORD_W    = WORD_W_DEFAULT,
  parameter logic [WORD_W-1:0] SYNC_PAT  = WORD_W'(SYNC_PAT_DEFAULT),
  parameter int unsigned       SYNC_NEED = 4,
  parameter int unsigned       SYNC_TMO  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              din_en,
  output logic [WORD_W-1:0] dout0,
  output logic [WORD_W-1:0] dout1,
  output logic              dout_valid,
  output logic              sync_seen,
  output logic              locked,
  output logic              lock_lost
);

  localparam int unsigned WIN_W  = 2 * WORD_W;
  localparam int unsigned BIT_W  = $clog2(WIN_W);
  localparam int unsigned TMO_W  = $clog2(SYNC_TMO + 1);
  localparam int unsigned GOOD_W = $clog2(SYNC_NEED + 1);

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIN_W - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SYNC_TMO - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(SYNC_NEED - 1);

  // The oldest window bit falls out on the next shift and is never read, so
  // only 2*WORD_W-1 bits of history are stored; the full post-shift window
  // is {history, din}.
  logic [WIN_W-2:0]  r_hist;
  logic [WIN_W-1:0]  w_win_next;
  logic [BIT_W-1:0]  r_bitcnt;
  logic [TMO_W-1:0]  r_tmo;
  logic [GOOD_W-1:0] r_goodcnt;
  state_t            r_state;

  logic [WORD_W-1:0] r_dout0;
  logic [WORD_W-1:0] r_dout1;
  logic              r_dout_valid;
  logic              r_sync_seen;
  logic              r_locked;
  logic              r_lock_lost;

  logic [WORD_W-1:0] w_lane0;
  logic [WORD_W-1:0] w_lane1;
  logic              w_match;
  logic              w_boundary;

  assign w_win_next = {r_hist, din};
  assign w_boundary = (r_bitcnt == BIT_LAST);

  demux_deinterleave #(
    .WORD_W   (WORD_W),
    .SYNC_PAT (SYNC_PAT)
  ) u_deint (
    .i_win        (w_win_next),
    .o_lane0      (w_lane0),
    .o_lane1      (w_lane1),
    .o_sync_match (w_match)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist       <= '0;
      r_bitcnt     <= '0;
      r_tmo        <= '0;
      r_goodcnt    <= '0;
      r_state      <= ST_HUNT;
      r_dout0      <= '0;
      r_dout1      <= '0;
      r_dout_valid <= 1'b0;
      r_sync_seen  <= 1'b0;
      r_locked     <= 1'b0;
      r_lock_lost  <= 1'b0;
    end else begin
      // Strobes are single-cycle; any enabled event below re-raises them.
      r_dout_valid <= 1'b0;
      r_sync_seen  <= 1'b0;
      r_lock_lost  <= 1'b0;

      if (din_en) begin
        r_hist   <= w_win_next[WIN_W-2:0];
        r_bitcnt <= w_boundary ? '0 : r_bitcnt + 1'b1;

        case (r_state)
          ST_VERIFY: begin
            if (w_boundary) begin
              if (w_match) begin
                if (r_goodcnt == GOOD_LAST) begin
                  r_state   <= ST_LOCKED;
                  r_locked  <= 1'b1;
                  r_goodcnt <= '0;
                  r_tmo     <= '0;
                end else begin
                  r_goodcnt <= r_goodcnt + 1'b1;
                end
              end else begin
                r_state   <= ST_HUNT;
                r_goodcnt <= '0;
              end
            end
          end

          ST_LOCKED: begin
            if (w_boundary) begin
              if (w_match) begin
                r_sync_seen <= 1'b1;
                r_tmo       <= '0;
              end else begin
                // The pair that hits the timeout is still delivered.
                r_dout0      <= w_lane0;
                r_dout1      <= w_lane1;
                r_dout_valid <= 1'b1;
                if (r_tmo == TMO_LAST) begin
                  r_state     <= ST_HUNT;
                  r_locked    <= 1'b0;
                  r_lock_lost <= 1'b1;
                  r_tmo       <= '0;
                end else begin
                  r_tmo <= r_tmo + 1'b1;
                end
              end
            end
          end

          default: begin
            // HUNT (and the unused code): bit-slip search on every bit.
            r_state <= ST_HUNT;
            if (w_match) begin
              r_state   <= ST_VERIFY;
              r_bitcnt  <= '0;
              r_goodcnt <= GOOD_W'(1);
            end
          end
        endcase
      end
    end
  end

  assign dout0      = r_dout0;
  assign dout1      = r_dout1;
  assign dout_valid = r_dout_valid;
  assign sync_seen  = r_sync_seen;
  assign locked     = r_locked;
  assign lock_lost  = r_lock_lost;

endmodule : serial_demux_1to2

// File: tb/tb_serial_demux_1to2.sv
module tb_serial_demux_1to2;

  localparam int unsigned W    = 8;
  localparam logic [7:0]  SYNC = 8'hBC;
  localparam int unsigned NEED = 4;
  localparam int unsigned TMO  = 64;

  // Event kinds recorded by the monitor and predicted by the model.
  localparam int EV_VALID = 1;
  localparam int EV_SYNC  = 2;
  localparam int EV_LOST  = 3;
  localparam int EV_LOCK  = 4;
  localparam int EV_UNLK  = 5;
  localparam int EV_GAP   = 6;  // strobe after an edge with din_en low

  typedef struct {
    int         kind;
    int         idx;
    logic [7:0] d0;
    logic [7:0] d1;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       din_en = 1'b0;
  logic [7:0] dout0, dout1;
  logic       dout_valid, sync_seen, locked, lock_lost;

  int checks = 0;
  int errors = 0;

  serial_demux_1to2 #(
    .WORD_W    (W),
    .SYNC_PAT  (SYNC),
    .SYNC_NEED (NEED),
    .SYNC_TMO  (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_en     (din_en),
    .dout0      (dout0),
    .dout1      (dout1),
    .dout_valid (dout_valid),
    .sync_seen  (sync_seen),
    .locked     (locked),
    .lock_lost  (lock_lost)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------------
  // Reference model: keeps the last 2W received bits as a list, decodes
  // lanes arithmetically, and tracks alignment as "bits since the sync
  // pair that started the current alignment".
  // ------------------------------------------------------------------
  logic       m_hist[$];
  int         m_mode;     // 0 searching, 1 confirming, 2 locked
  int         m_since;
  int         m_good;
  int         m_nosync;
  logic [7:0] m_d0, m_d1;
  bit         m_valid, m_sync, m_lost, m_locked, m_prev_locked;

  ev_t  obs_q[$];
  ev_t  exp_q[$];
  logic tx[$];
  int   bit_idx;
  bit   obs_prev_locked;

  function automatic void model_reset();
    m_hist.delete();
    for (int i = 0; i < 2*W; i++) m_hist.push_back(1'b0);
    m_mode = 0; m_since = 0; m_good = 0; m_nosync = 0;
    m_d0 = '0; m_d1 = '0;
    m_valid = 0; m_sync = 0; m_lost = 0; m_locked = 0; m_prev_locked = 0;
  endfunction

  function automatic void model_step(input logic b);
    logic [7:0] l0, l1;
    bit match, boundary;
    m_valid = 0; m_sync = 0; m_lost = 0;
    m_hist.push_back(b);
    void'(m_hist.pop_front());
    l0 = '0; l1 = '0;
    for (int i = 0; i < W; i++) begin
      l0 = {l0[6:0], m_hist[2*i]};
      l1 = {l1[6:0], m_hist[2*i+1]};
    end
    match = (l0 == SYNC) && (l1 == ~SYNC);
    m_since++;
    boundary = (m_since % (2*W)) == 0;
    case (m_mode)
      0: if (match) begin m_mode = 1; m_since = 0; m_good = 1; end
      1: if (boundary) begin
           if (match) begin
             m_good++;
             if (m_good == NEED) begin m_mode = 2; m_nosync = 0; end
           end else begin
             m_mode = 0; m_good = 0;
           end
         end
      default: if (boundary) begin
           if (match) begin
             m_sync = 1; m_nosync = 0;
           end else begin
             m_valid = 1; m_d0 = l0; m_d1 = l1; m_nosync++;
             if (m_nosync == TMO) begin m_mode = 0; m_lost = 1; end
           end
         end
    endcase
    m_locked = (m_mode == 2);
  endfunction

  function automatic void push_pair(input logic [7:0] a, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      tx.push_back(a[i]);
      tx.push_back(b[i]);
    end
  endfunction

  function automatic int count_kind(input int kind);
    int n = 0;
    foreach (obs_q[i]) if (obs_q[i].kind == kind) n++;
    return n;
  endfunction

  function automatic int first_idx(input int kind);
    foreach (obs_q[i]) if (obs_q[i].kind == kind) return obs_q[i].idx;
    return -1;
  endfunction

  function automatic int last_idx(input int kind);
    int r = -1;
    foreach (obs_q[i]) if (obs_q[i].kind == kind) r = obs_q[i].idx;
    return r;
  endfunction

  // One clock: drive on the falling edge, sample 1 time unit after the
  // rising edge, record observed and predicted events.
  task automatic drive_bit(input logic b, input logic en);
    @(negedge clk);
    din = b;
    din_en = en;
    @(posedge clk);
    #1;
    if (en) begin
      bit_idx++;
      model_step(b);
      if (m_valid) exp_q.push_back('{EV_VALID, bit_idx, m_d0, m_d1});
      if (m_sync)  exp_q.push_back('{EV_SYNC, bit_idx, 8'h00, 8'h00});
      if (m_lost)  exp_q.push_back('{EV_LOST, bit_idx, 8'h00, 8'h00});
    end
    if (m_locked && !m_prev_locked) exp_q.push_back('{EV_LOCK, bit_idx, 8'h00, 8'h00});
    if (!m_locked && m_prev_locked) exp_q.push_back('{EV_UNLK, bit_idx, 8'h00, 8'h00});
    m_prev_locked = m_locked;

    if (dout_valid) obs_q.push_back('{en ? EV_VALID : EV_GAP, bit_idx, dout0, dout1});
    if (sync_seen)  obs_q.push_back('{en ? EV_SYNC : EV_GAP, bit_idx, 8'h00, 8'h00});
    if (lock_lost)  obs_q.push_back('{en ? EV_LOST : EV_GAP, bit_idx, 8'h00, 8'h00});
    if (locked && !obs_prev_locked) obs_q.push_back('{EV_LOCK, bit_idx, 8'h00, 8'h00});
    if (!locked && obs_prev_locked) obs_q.push_back('{EV_UNLK, bit_idx, 8'h00, 8'h00});
    obs_prev_locked = locked;
  endtask

  task automatic play(input int gap_pct);
    while (tx.size() > 0) begin
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct)
        drive_bit(1'($urandom_range(1)), 1'b0);
      else
        drive_bit(tx.pop_front(), 1'b1);
    end
    repeat (2) drive_bit(1'($urandom_range(1)), 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; din = 1'b0; din_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    obs_q.delete(); exp_q.delete(); tx.delete();
    bit_idx = 0;
    obs_prev_locked = 1'b0;
  endtask

  // ------------------------------------------------------------------
  task automatic test_reset();
    #1;
    checks++;
    if ({dout0, dout1} !== 16'h0000) begin
      errors++; $display("FAIL reset_data: got %h/%h expected 00/00", dout0, dout1);
    end
    checks++;
    if ({dout_valid, sync_seen, locked, lock_lost} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000",
                         {dout_valid, sync_seen, locked, lock_lost});
    end
  endtask

  task automatic test_basic_lock();
    apply_reset();
    repeat (4) push_pair(SYNC, ~SYNC);
    push_pair(8'hA5, 8'h5A);
    play(0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL basic_evcount: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].kind != exp_q[i].kind || obs_q[i].idx != exp_q[i].idx ||
          obs_q[i].d0 !== exp_q[i].d0 || obs_q[i].d1 !== exp_q[i].d1) begin
        errors++;
        $display("FAIL basic_ev%0d: got k%0d@%0d %h/%h expected k%0d@%0d %h/%h", i,
                 obs_q[i].kind, obs_q[i].idx, obs_q[i].d0, obs_q[i].d1,
                 exp_q[i].kind, exp_q[i].idx, exp_q[i].d0, exp_q[i].d1);
      end
    end
    checks++;
    if (first_idx(EV_LOCK) != 64) begin
      errors++; $display("FAIL basic_lock_at: got %0d expected 64", first_idx(EV_LOCK));
    end
    checks++;
    if (count_kind(EV_VALID) != 1 || first_idx(EV_VALID) != 80 || dout0 !== 8'hA5 || dout1 !== 8'h5A) begin
      errors++; $display("FAIL basic_pair: got n=%0d @%0d %h/%h expected n=1 @80 a5/5a",
                         count_kind(EV_VALID), first_idx(EV_VALID), dout0, dout1);
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL basic_locked: got %b expected 1", locked);
    end
  endtask

  task automatic test_bit_slip();
    apply_reset();
    repeat (3) tx.push_back(1'($urandom_range(1)));
    repeat (4) push_pair(SYNC, ~SYNC);
    push_pair(8'hA5, 8'h5A);
    play(0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL slip_evcount: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].kind != exp_q[i].kind || obs_q[i].idx != exp_q[i].idx ||
          obs_q[i].d0 !== exp_q[i].d0 || obs_q[i].d1 !== exp_q[i].d1) begin
        errors++;
        $display("FAIL slip_ev%0d: got k%0d@%0d %h/%h expected k%0d@%0d %h/%h", i,
                 obs_q[i].kind, obs_q[i].idx, obs_q[i].d0, obs_q[i].d1,
                 exp_q[i].kind, exp_q[i].idx, exp_q[i].d0, exp_q[i].d1);
      end
    end
    checks++;
    if (first_idx(EV_LOCK) != 67 || first_idx(EV_VALID) != 83 || count_kind(EV_VALID) != 1 ||
        dout0 !== 8'hA5 || dout1 !== 8'h5A) begin
      errors++; $display("FAIL slip_anchor: got lock@%0d valid@%0d n=%0d %h/%h expected lock@67 valid@83 n=1 a5/5a",
                         first_idx(EV_LOCK), first_idx(EV_VALID), count_kind(EV_VALID), dout0, dout1);
    end
  endtask

  task automatic test_verify_fail();
    apply_reset();
    push_pair(SYNC, ~SYNC);
    push_pair(8'hBD, 8'h43);
    repeat (4) push_pair(SYNC, ~SYNC);
    push_pair(8'hA5, 8'h5A);
    play(0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL verify_evcount: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].kind != exp_q[i].kind || obs_q[i].idx != exp_q[i].idx ||
          obs_q[i].d0 !== exp_q[i].d0 || obs_q[i].d1 !== exp_q[i].d1) begin
        errors++;
        $display("FAIL verify_ev%0d: got k%0d@%0d %h/%h expected k%0d@%0d %h/%h", i,
                 obs_q[i].kind, obs_q[i].idx, obs_q[i].d0, obs_q[i].d1,
                 exp_q[i].kind, exp_q[i].idx, exp_q[i].d0, exp_q[i].d1);
      end
    end
    checks++;
    if (first_idx(EV_LOCK) != 96 || first_idx(EV_VALID) != 112 || dout0 !== 8'hA5) begin
      errors++; $display("FAIL verify_anchor: got lock@%0d valid@%0d d0=%h expected lock@96 valid@112 d0=a5",
                         first_idx(EV_LOCK), first_idx(EV_VALID), dout0);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] a, b;
    apply_reset();
    repeat (4) push_pair(SYNC, ~SYNC);
    a = '0; b = '0;
    for (int i = 0; i < int'(TMO); i++) begin
      a = 8'($urandom); b = 8'($urandom);
      if (a == SYNC && b == ~SYNC) b = b ^ 8'h01;
      push_pair(a, b);
    end
    play(0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL tmo_evcount: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].kind != exp_q[i].kind || obs_q[i].idx != exp_q[i].idx ||
          obs_q[i].d0 !== exp_q[i].d0 || obs_q[i].d1 !== exp_q[i].d1) begin
        errors++;
        $display("FAIL tmo_ev%0d: got k%0d@%0d %h/%h expected k%0d@%0d %h/%h", i,
                 obs_q[i].kind, obs_q[i].idx, obs_q[i].d0, obs_q[i].d1,
                 exp_q[i].kind, exp_q[i].idx, exp_q[i].d0, exp_q[i].d1);
      end
    end
    checks++;
    if (count_kind(EV_VALID) != 64 || first_idx(EV_LOST) != 1088 ||
        last_idx(EV_VALID) != 1088 || first_idx(EV_UNLK) != 1088) begin
      errors++; $display("FAIL tmo_anchor: got n=%0d lost@%0d lastvalid@%0d unlock@%0d expected 64 1088 1088 1088",
                         count_kind(EV_VALID), first_idx(EV_LOST), last_idx(EV_VALID), first_idx(EV_UNLK));
    end
    checks++;
    if (locked !== 1'b0 || dout0 !== a || dout1 !== b) begin
      errors++; $display("FAIL tmo_hold: got locked=%b %h/%h expected locked=0 %h/%h",
                         locked, dout0, dout1, a, b);
    end
  endtask

  task automatic test_sync_refresh();
    apply_reset();
    repeat (4) push_pair(SYNC, ~SYNC);
    repeat (63) push_pair(8'h12, 8'h34);
    push_pair(SYNC, ~SYNC);
    repeat (64) push_pair(8'h56, 8'h78);
    play(0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL refresh_evcount: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].kind != exp_q[i].kind || obs_q[i].idx != exp_q[i].idx ||
          obs_q[i].d0 !== exp_q[i].d0 || obs_q[i].d1 !== exp_q[i].d1) begin
        errors++;
        $display("FAIL refresh_ev%0d: got k%0d@%0d %h/%h expected k%0d@%0d %h/%h", i,
                 obs_q[i].kind, obs_q[i].idx, obs_q[i].d0, obs_q[i].d1,
                 exp_q[i].kind, exp_q[i].idx, exp_q[i].d0, exp_q[i].d1);
      end
    end
    checks++;
    if (count_kind(EV_SYNC) != 1 || first_idx(EV_SYNC) != 1088 ||
        count_kind(EV_VALID) != 127 || first_idx(EV_LOST) != 2112) begin
      errors++; $display("FAIL refresh_anchor: got sync n=%0d @%0d valid n=%0d lost@%0d expected 1 @1088 127 @2112",
                         count_kind(EV_SYNC), first_idx(EV_SYNC), count_kind(EV_VALID), first_idx(EV_LOST));
    end
  endtask

  task automatic test_gaps();
    apply_reset();
    repeat (4) push_pair(SYNC, ~SYNC);
    push_pair(8'hA5, 8'h5A);
    play(30);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL gaps_evcount: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].kind != exp_q[i].kind || obs_q[i].idx != exp_q[i].idx ||
          obs_q[i].d0 !== exp_q[i].d0 || obs_q[i].d1 !== exp_q[i].d1) begin
        errors++;
        $display("FAIL gaps_ev%0d: got k%0d@%0d %h/%h expected k%0d@%0d %h/%h", i,
                 obs_q[i].kind, obs_q[i].idx, obs_q[i].d0, obs_q[i].d1,
                 exp_q[i].kind, exp_q[i].idx, exp_q[i].d0, exp_q[i].d1);
      end
    end
    checks++;
    if (count_kind(EV_GAP) != 0 || first_idx(EV_LOCK) != 64 || first_idx(EV_VALID) != 80 ||
        dout0 !== 8'hA5 || dout1 !== 8'h5A) begin
      errors++; $display("FAIL gaps_anchor: got gapstrobes=%0d lock@%0d valid@%0d %h/%h expected 0 64 80 a5/5a",
                         count_kind(EV_GAP), first_idx(EV_LOCK), first_idx(EV_VALID), dout0, dout1);
    end
  endtask

  task automatic test_lane_swap();
    apply_reset();
    repeat (6) push_pair(~SYNC, SYNC);
    push_pair(8'h5A, 8'hA5);
    play(0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL swap_evcount: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    checks++;
    if (obs_q.size() != 0 || locked !== 1'b0) begin
      errors++; $display("FAIL swap_nolock: got events=%0d locked=%b expected 0 0", obs_q.size(), locked);
    end
  endtask

  task automatic test_mid_word_reset();
    apply_reset();
    repeat (4) push_pair(SYNC, ~SYNC);
    push_pair(8'hA5, 8'h5A);
    play(0);
    repeat (7) drive_bit(1'($urandom_range(1)), 1'b1);
    checks++;
    if (locked !== 1'b1 || dout0 !== 8'hA5) begin
      errors++; $display("FAIL rst_pre: got locked=%b d0=%h expected 1 a5", locked, dout0);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({dout0, dout1, dout_valid, sync_seen, locked, lock_lost} !== 20'h0) begin
      errors++; $display("FAIL rst_async: got %h/%h %b expected 00/00 0000", dout0, dout1,
                         {dout_valid, sync_seen, locked, lock_lost});
    end
    apply_reset();
    repeat (3) push_pair(SYNC, ~SYNC);
    push_pair(8'h11, 8'h22);
    repeat (4) push_pair(SYNC, ~SYNC);
    push_pair(8'h3C, 8'hC3);
    play(0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL relock_evcount: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].kind != exp_q[i].kind || obs_q[i].idx != exp_q[i].idx ||
          obs_q[i].d0 !== exp_q[i].d0 || obs_q[i].d1 !== exp_q[i].d1) begin
        errors++;
        $display("FAIL relock_ev%0d: got k%0d@%0d %h/%h expected k%0d@%0d %h/%h", i,
                 obs_q[i].kind, obs_q[i].idx, obs_q[i].d0, obs_q[i].d1,
                 exp_q[i].kind, exp_q[i].idx, exp_q[i].d0, exp_q[i].d1);
      end
    end
    checks++;
    if (first_idx(EV_LOCK) != 128 || count_kind(EV_VALID) != 1 || first_idx(EV_VALID) != 144 ||
        dout0 !== 8'h3C || dout1 !== 8'hC3) begin
      errors++; $display("FAIL relock_anchor: got lock@%0d n=%0d valid@%0d %h/%h expected 128 1 144 3c/c3",
                         first_idx(EV_LOCK), count_kind(EV_VALID), first_idx(EV_VALID), dout0, dout1);
    end
  endtask

  initial begin
    model_reset();
    bit_idx = 0;
    obs_prev_locked = 1'b0;
    test_reset();
    test_basic_lock();
    test_bit_slip();
    test_verify_fail();
    test_timeout();
    test_sync_refresh();
    test_gaps();
    test_lane_swap();
    test_mid_word_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_demux_1to2
